// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller: FSM state
// encoding, response fault codes and the list of legal store byte masks.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam logic [1:0] FaultNone  = 2'b00;
    localparam logic [1:0] FaultMask  = 2'b01;
    localparam logic [1:0] FaultRange = 2'b10;

    localparam int unsigned NumLegalMasks = 7;

    // Byte, aligned halfword and full word lanes only.
    localparam logic [3:0] LegalMasks [NumLegalMasks] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
    };

    function automatic logic mask_is_legal(input logic [3:0] mask);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < NumLegalMasks; i++) begin
            if (mask == LegalMasks[i]) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// Contents are intentionally not reset.
module dmem_bank #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read data only changes on an access, so it stays stable while a response waits.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_q[addr];
        end
    end

    // Byte-lane write commit and read-data capture.
    always_ff @(posedge clock) begin
        if (en && we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: accepts one load/store, waits
// WAIT_CYCLES, performs the access on the edge entering RESP and holds the
// response until consumed.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to fault word indices >= DEPTH
// instead of wrapping them modulo DEPTH.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [1:0]    fault_q, fault_d;

    logic          req_oob;
    logic [1:0]    fault_now;
    logic          go_access;
    logic          sel_live;
    logic          acc_write;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wmask;
    logic [1:0]    acc_fault;
    logic          bank_we;
    logic [31:0]   bank_rdata;
    logic          unused_addr;

    // Byte offset is ignored; upper bits only matter with bounds checking.
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    // Classify the incoming request; range fault wins over mask fault.
    always_comb begin
        req_oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        req_oob = |req_addr[31:AW+2];
`endif
        fault_now = FaultNone;
        if (req_oob) begin
            fault_now = FaultRange;
        end else if (req_write && !mask_is_legal(req_wmask)) begin
            fault_now = FaultMask;
        end
    end

    // Next-state, request capture and access-strobe generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        fault_d   = fault_q;
        go_access = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    fault_d = fault_now;
                    cnt_d   = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = StResp;
                        go_access = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    state_d   = StResp;
                    go_access = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and captured request; reset drops any pending store.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            fault_q <= FaultNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            fault_q <= fault_d;
        end
    end

    // With zero wait cycles the access happens on the accept edge, before capture.
    always_comb begin
        sel_live  = (state_q == StIdle);
        acc_write = sel_live ? req_write : write_q;
        acc_idx   = sel_live ? req_addr[AW+1:2] : idx_q;
        acc_wdata = sel_live ? req_wdata : wdata_q;
        acc_wmask = sel_live ? req_wmask : wmask_q;
        acc_fault = sel_live ? fault_now : fault_q;
        bank_we   = go_access && acc_write && (acc_fault == FaultNone);
    end

    dmem_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clock (clock),
        .en    (go_access),
        .we    (bank_we),
        .be    (acc_wmask),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (bank_rdata)
    );

    // Outputs decode directly from registered state so reset clears them at once.
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_fault = rsp_valid ? fault_q : FaultNone;
        rsp_rdata = 32'd0;
        if (rsp_valid && !write_q && (fault_q == FaultNone)) begin
            rsp_rdata = bank_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (DEPTH=256, WAIT_CYCLES=1).
module tb_dmem_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    int total = 0;
    int bad   = 0;

    dmem_ctrl #(
        .DEPTH       (256),
        .WAIT_CYCLES (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one request from IDLE, wait (bounded) for rsp_valid, leave it unconsumed.
    // lat counts cycles from the request cycle to the first cycle with rsp_valid high.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output logic [31:0] rdata,
                         output logic [1:0] fault, output int lat);
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
        end
        rdata = rsp_rdata;
        fault = rsp_fault;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        total++; if (rsp_fault !== 2'b00) begin bad++; $display("FAIL reset_fault: got %b want 00", rsp_fault); end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, ft, lat);
        total++; if (ft !== 2'b00) begin bad++; $display("FAIL sw_fault: got %b want 00", ft); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL sw_rdata: got %h want 0", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
        release_rsp();
        issue(1'b0, 32'h10, 32'h0, 4'b0000, rd, ft, lat);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        total++; if (ft !== 2'b00) begin bad++; $display("FAIL lw_fault: got %b want 00", ft); end
        total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
        release_rsp();
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, ft, lat);
        total++; if (ft !== 2'b00) begin bad++; $display("FAIL sb_fault: got %b want 00", ft); end
        release_rsp();
        issue(1'b0, 32'h10, 32'h0, 4'b0000, rd, ft, lat);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL sb_readback: got %h want deadbeaa", rd); end
        release_rsp();
        issue(1'b1, 32'h14, 32'h11112222, 4'b1111, rd, ft, lat);
        release_rsp();
        issue(1'b1, 32'h17, 32'hABCD0000, 4'b1100, rd, ft, lat);
        release_rsp();
        issue(1'b0, 32'h14, 32'h0, 4'b0000, rd, ft, lat);
        total++; if (rd !== 32'hABCD2222) begin bad++; $display("FAIL sh_readback: got %h want abcd2222", rd); end
        release_rsp();
    endtask

    task automatic test_illegal_mask();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b1, 32'h20, 32'h55667788, 4'b1111, rd, ft, lat);
        release_rsp();
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, rd, ft, lat);
        total++; if (ft !== 2'b01) begin bad++; $display("FAIL mask0101_fault: got %b want 01", ft); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL mask0101_rdata: got %h want 0", rd); end
        release_rsp();
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0110, rd, ft, lat);
        total++; if (ft !== 2'b01) begin bad++; $display("FAIL mask0110_fault: got %b want 01", ft); end
        release_rsp();
        issue(1'b0, 32'h20, 32'h0, 4'b0101, rd, ft, lat);
        total++; if (ft !== 2'b00) begin bad++; $display("FAIL load_mask_ignored: got %b want 00", ft); end
        total++; if (rd !== 32'h55667788) begin bad++; $display("FAIL mask_unchanged: got %h want 55667788", rd); end
        release_rsp();
    endtask

    task automatic test_bounds();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, rd, ft, lat);
        release_rsp();
        issue(1'b0, 32'h400, 32'h0, 4'b0000, rd, ft, lat);
`ifdef DMEM_BOUNDS_CHECK_EN
        total++; if (ft !== 2'b10) begin bad++; $display("FAIL oob_load_fault: got %b want 10", ft); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL oob_load_rdata: got %h want 0", rd); end
`else
        total++; if (ft !== 2'b00) begin bad++; $display("FAIL wrap_load_fault: got %b want 00", ft); end
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_load_rdata: got %h want cafef00d", rd); end
`endif
        release_rsp();
        issue(1'b1, 32'h400, 32'h0, 4'b0101, rd, ft, lat);
`ifdef DMEM_BOUNDS_CHECK_EN
        total++; if (ft !== 2'b10) begin bad++; $display("FAIL fault_priority: got %b want 10", ft); end
`else
        total++; if (ft !== 2'b01) begin bad++; $display("FAIL wrap_mask_fault: got %b want 01", ft); end
`endif
        release_rsp();
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b0, 32'h10, 32'h0, 4'b0000, rd, ft, lat);
        // A request offered while busy must be ignored.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_wmask = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
            total++; if (rsp_rdata !== 32'hDEADBEAA) begin bad++; $display("FAIL hold_rdata[%0d]: got %h want deadbeaa", i, rsp_rdata); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        release_rsp();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_after_release: got %b want 1", req_ready); end
        issue(1'b0, 32'h10, 32'h0, 4'b0000, rd, ft, lat);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL busy_req_ignored: got %h want deadbeaa", rd); end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b0, 32'h20, 32'h0, 4'b0000, rd, ft, lat);
        release_rsp();
        issue(1'b0, 32'h14, 32'h0, 4'b0000, rd, ft, lat);
        total++; if (rd !== 32'hABCD2222) begin bad++; $display("FAIL b2b_rdata: got %h want abcd2222", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL b2b_latency: got %0d want 2", lat); end
        release_rsp();
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        issue(1'b1, 32'h30, 32'h0BADF00D, 4'b1111, rd, ft, lat);
        release_rsp();
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_wmask = 4'b1111;
        @(posedge clock); #1;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL in_wait: req_ready got %b want 0", req_ready); end
        reset = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_wait_req_ready: got %b want 1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_wait_rdata: got %h want 0", rsp_rdata); end
        total++; if (rsp_fault !== 2'b00) begin bad++; $display("FAIL rst_wait_fault: got %b want 00", rsp_fault); end
        #2;
        reset = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 4'b0000, rd, ft, lat);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL rst_no_commit: got %h want 0badf00d", rd); end
        release_rsp();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_wmask = 4'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_partial_store();
        test_illegal_mask();
        test_bounds();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
